// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one instruction-memory request at a time and
// feeds the IF/ID register; honours StallD from ID and branch redirects from EX.
module fetch_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_d,
    input  logic            branch_taken_ex,
    input  logic [XLEN-1:0] branch_target_ex,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_id,
    output logic [XLEN-1:0] pc_id,
    output logic            valid_id,
    output logic            fetch_busy
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, instr_nx, pc_id_nx;
    logic [XLEN-1:0] hold_instr, hold_instr_nx, hold_pc, hold_pc_nx;
    logic            valid_nx;

    assign imem_req   = state == S_REQ;
    assign imem_addr  = pc;
    assign fetch_busy = state == S_WAIT || state == S_DROP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            instr_id   <= NOP_INSTR;
            pc_id      <= '0;
            valid_id   <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            instr_id   <= instr_nx;
            pc_id      <= pc_id_nx;
            valid_id   <= valid_nx;
            hold_instr <= hold_instr_nx;
            hold_pc    <= hold_pc_nx;
        end
    end

    // Without a load, IF/ID either freezes (stall) or collapses to a bubble.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        instr_nx      = stall_d ? instr_id : NOP_INSTR;
        pc_id_nx      = pc_id;
        valid_nx      = stall_d & valid_id;
        hold_instr_nx = hold_instr;
        hold_pc_nx    = hold_pc;
        if (branch_taken_ex) begin
            pc_nx         = branch_target_ex & ~XLEN'(3);
            instr_nx      = NOP_INSTR;
            valid_nx      = 1'b0;
            hold_instr_nx = '0;
            hold_pc_nx    = '0;
            // A request still owed a response must have that response swallowed.
            state_nx = (state == S_DROP || (state == S_REQ && imem_ready) ||
                        (state == S_WAIT && !imem_rvalid)) ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_IDLE: state_nx = S_REQ;
                S_REQ:  state_nx = imem_ready ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid && stall_d) begin
                        hold_instr_nx = imem_rdata;
                        hold_pc_nx    = pc;
                        state_nx      = S_HOLD;
                    end else if (imem_rvalid) begin
                        instr_nx = imem_rdata;
                        pc_id_nx = pc;
                        valid_nx = 1'b1;
                        pc_nx    = pc + XLEN'(4);
                        state_nx = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!stall_d) begin
                        instr_nx = hold_instr;
                        pc_id_nx = hold_pc;
                        valid_nx = 1'b1;
                        pc_nx    = pc + XLEN'(4);
                        state_nx = S_REQ;
                    end
                end
                S_DROP:  state_nx = imem_rvalid ? S_REQ : S_DROP;
                default: state_nx = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run, checked against an
// instruction-stream model (sequential PCs, restarted by redirects) and a memory model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_d = 1'b0, branch_taken_ex = 1'b0;
    logic [31:0] branch_target_ex = '0;
    logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr_id, pc_id;
    logic        valid_id, fetch_busy;

    int vectors = 0;
    int miscompares = 0;

    logic        mem_rand = 1'b0, ready_force = 1'b1;
    int          lat = 0;
    logic        pend = 1'b0, req_s = 1'b0;
    logic [31:0] addr_s = '0, p_addr = '0;
    int          cnt = 0;
    logic [31:0] acc_q[$];

    logic [31:0] exp_pc = '0, p_instr = NOP, p_pc = '0;
    logic        p_valid = 1'b0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .branch_taken_ex(branch_taken_ex),
        .branch_target_ex(branch_target_ex), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_id && n < 60) begin tick(); n++; end
        chk(tag, 32'(valid_id), 1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 60) begin tick(); n++; end
        chk(tag, 32'(imem_req), 1);
    endtask

    task automatic wait_fetch(input logic [31:0] a, input string tag);
        int n = 0;
        while (!(fetch_busy && imem_addr == a) && n < 60) begin tick(); n++; end
        chk(tag, 32'(fetch_busy && imem_addr == a), 1);
    endtask

    // Memory: accepts on req&&ready, answers one or more cycles later with addr^KEY.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0; req_s = 1'b0;
            end else begin
                if (imem_rvalid) begin imem_rvalid = 1'b0; pend = 1'b0; end
                if (req_s && imem_ready) begin
                    pend = 1'b1;
                    cnt = mem_rand ? int'($urandom_range(0, 3)) : lat;
                    p_addr = addr_s;
                    acc_q.push_back(addr_s);
                end
                if (pend && !imem_rvalid) begin
                    if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = p_addr ^ KEY; end
                    else cnt--;
                end
                chk("one_outstanding", 32'(imem_req && pend), 0);
                imem_ready = mem_rand ? 1'($urandom_range(0, 1)) : ready_force;
                req_s = imem_req;
                addr_s = imem_addr;
            end
        end
    end

    // Stream model: each fresh valid IF/ID entry must be the next sequential PC.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("rst_valid", 32'(valid_id), 0);
                chk("rst_instr", instr_id, NOP);
                chk("rst_req", 32'(imem_req), 0);
                exp_pc = 32'h0;
                p_instr = NOP; p_pc = 32'h0; p_valid = 1'b0;
            end else begin
                if (branch_taken_ex) begin
                    chk("redir_valid", 32'(valid_id), 0);
                    chk("redir_instr", instr_id, NOP);
                    exp_pc = branch_target_ex & 32'hFFFF_FFFC;
                end else if (stall_d) begin
                    chk("stall_instr", instr_id, p_instr);
                    chk("stall_pc", pc_id, p_pc);
                    chk("stall_valid", 32'(valid_id), 32'(p_valid));
                end else if (valid_id) begin
                    chk("stream_pc", pc_id, exp_pc);
                    chk("stream_instr", instr_id, exp_pc ^ KEY);
                    exp_pc = exp_pc + 32'd4;
                end else begin
                    chk("bubble_instr", instr_id, NOP);
                    chk("bubble_pc", pc_id, p_pc);
                end
                p_instr = instr_id; p_pc = pc_id; p_valid = valid_id;
            end
        end
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", 32'(fetch_busy), 0);
        chk("reset_pc_id", pc_id, 0);
        rst = 1'b1;
        chk("idle_no_req", 32'(imem_req), 0);
        tick();
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", imem_addr, 0);
        // free run, zero-wait memory
        wait_valid("wait_i0");
        chk("i0_instr", instr_id, 32'hA5A5_0000);
        chk("i0_pc", pc_id, 0);
        tick();
        chk("bubble_between", 32'(valid_id), 0);
        wait_valid("wait_i1");
        chk("i1_instr", instr_id, 32'hA5A5_0004);
        chk("i1_pc", pc_id, 4);
        // stall on return of pc 8
        wait_fetch(32'h8, "wait_f8");
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_no_req", 32'(imem_req), 0);
        end
        stall_d = 1'b0;
        tick();
        chk("unstall_instr", instr_id, 32'h8 ^ KEY);
        chk("unstall_pc", pc_id, 8);
        chk("unstall_valid", 32'(valid_id), 1);
        chk("next_addr12", imem_addr, 12);
        chk("acc_count", 32'(acc_q.size() >= 3), 1);
        chk("acc0", acc_q[0], 0);
        chk("acc1", acc_q[1], 4);
        chk("acc2", acc_q[2], 8);
        // redirect while waiting for pc 16
        lat = 3;
        wait_fetch(32'h10, "wait_f16");
        branch_taken_ex = 1'b1; branch_target_ex = 32'h100;
        tick();
        branch_taken_ex = 1'b0;
        chk("drop_busy", 32'(fetch_busy), 1);
        chk("drop_no_req", 32'(imem_req), 0);
        wait_req("wait_req100");
        chk("req100_addr", imem_addr, 32'h100);
        chk("req100_valid", 32'(valid_id), 0);
        lat = 0;
        wait_valid("wait_i100");
        chk("i100_pc", pc_id, 32'h100);
        chk("i100_instr", instr_id, 32'h100 ^ KEY);
        // redirect together with stall while holding
        wait_fetch(32'h104, "wait_f104");
        stall_d = 1'b1;
        tick();
        chk("hold_busy", 32'(fetch_busy), 0);
        chk("hold_req", 32'(imem_req), 0);
        branch_taken_ex = 1'b1; branch_target_ex = 32'h200;
        tick();
        branch_taken_ex = 1'b0; stall_d = 1'b0;
        chk("rs_valid", 32'(valid_id), 0);
        chk("rs_instr", instr_id, NOP);
        chk("rs_addr", imem_addr, 32'h200);
        chk("rs_req", 32'(imem_req), 1);
        wait_valid("wait_i200");
        chk("i200_pc", pc_id, 32'h200);
        chk("i200_instr", instr_id, 32'h200 ^ KEY);
        // back-pressure at the top of the address space, then wrap
        ready_force = 1'b0;
        wait_req("wait_req_bp");
        branch_taken_ex = 1'b1; branch_target_ex = 32'hFFFF_FFFF;
        tick();
        branch_taken_ex = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_req", 32'(imem_req), 1);
            chk("bp_addr", imem_addr, 32'hFFFF_FFFC);
            tick();
        end
        ready_force = 1'b1;
        wait_valid("wait_iwrap");
        chk("wrap_pc", pc_id, 32'hFFFF_FFFC);
        chk("wrap_instr", instr_id, 32'hFFFF_FFFC ^ KEY);
        chk("wrap_addr", imem_addr, 0);
        chk("wrap_req", 32'(imem_req), 1);
        // randomized traffic
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall_d = $urandom_range(0, 99) < 30;
            branch_taken_ex = $urandom_range(0, 99) < 4;
            branch_target_ex = $urandom;
            tick();
        end
        stall_d = 1'b0; branch_taken_ex = 1'b0; mem_rand = 1'b0; ready_force = 1'b1;
        repeat (10) tick();
        // asynchronous reset while a fetch is in flight
        lat = 3;
        begin
            int n = 0;
            while (!(fetch_busy && !imem_req) && n < 60) begin tick(); n++; end
            chk("wait_busy_rst", 32'(fetch_busy), 1);
        end
        #1 rst = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 0);
        chk("arst_busy", 32'(fetch_busy), 0);
        chk("arst_valid", 32'(valid_id), 0);
        chk("arst_instr", instr_id, NOP);
        chk("arst_pc_id", pc_id, 0);
        chk("arst_addr", imem_addr, 0);
        lat = 0;
        repeat (2) tick();
        rst = 1'b1;
        wait_valid("wait_after_rst");
        chk("after_rst_pc", pc_id, 0);
        chk("after_rst_instr", instr_id, KEY);
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
